// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular transmit FIFO that feeds a UART transmitter through a start/done handshake.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic                 tx_start,
  output logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_done_tick,
  output logic                 busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_e;
  localparam logic [ADDR_BITS:0] PTR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];
  logic [ADDR_BITS:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic                 tx_start_q, busy_q;
  logic [DATA_BITS-1:0] tx_data_q;
  state_e               state_q;
  logic                 push, pop;
  assign empty    = wr_ptr_q == rd_ptr_q;
  assign full     = (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]) &&
                    (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  // Both decisions use pre-edge flags, so a pop never makes room for a same-cycle write.
  assign push = wr_en && !full;
  assign pop  = (state_q == S_IDLE) && !empty;
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = (wr_en && full) ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= wr_data;
  end
  // S_GAP keeps a new start off the transmitter's done-tick cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (pop) begin
          tx_data_q  <= mem_q[rd_ptr_q[ADDR_BITS-1:0]];
          tx_start_q <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= S_WAIT;
        end
        S_WAIT: if (tx_done_tick) begin
          busy_q  <= 1'b0;
          state_q <= S_GAP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer and sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from a host write port into a circular FIFO.
- Drains the FIFO one word at a time into the transmitter using its tx_start / tx_data / tx_done_tick handshake.
- Lets software queue bursts without polling per byte; reports fill level, full/empty, and a sticky overflow flag.

Parameters:
- DATA_BITS, 8, width of each queued word; must match the transmitter's DATA_BITS.
- ADDR_BITS, 4, FIFO address width; depth = 2**ADDR_BITS (default 16).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  host write strobe; one word per cycle while high.
- wr_data  input  DATA_BITS  word to enqueue.
- full  output  1  FIFO holds 2**ADDR_BITS words.
- empty  output  1  FIFO holds 0 words.
- count  output  ADDR_BITS+1  current number of stored words.
- overflow  output  1  sticky; set when a write is dropped because the FIFO is full.
- clr_overflow  input  1  single-cycle pulse clearing overflow.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  output  DATA_BITS  word presented to the transmitter; held stable until the next pop.
- tx_done_tick  input  1  one-cycle pulse from the transmitter marking end of stop bit.
- busy  output  1  high from pop until tx_done_tick is received.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low on reset_n; all state is clocked on posedge clk.
- Reset values:
  - full=0, empty=1, count=0, overflow=0, tx_start=0, tx_data=0, busy=0.
  - Read/write pointers=0; FSM in S_IDLE.
- Storage:
  - Circular array of 2**ADDR_BITS words.
  - wr_ptr and rd_ptr are ADDR_BITS+1 bits; the MSB distinguishes wrap.
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal and MSBs differ).
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_BITS+1).
  - full, empty and count are registered-derived, with no combinational path from wr_en.
- Write:
  - When wr_en=1 and the FIFO is not full: store wr_data at wr_ptr and increment wr_ptr.
  - When wr_en=1 and the FIFO is full: drop the word, leave pointers unchanged, set overflow=1 next cycle.
  - overflow stays set until clr_overflow=1.
  - If a drop and clr_overflow occur in the same cycle, set wins.
- Pop (internal, FSM-driven):
  - Load mem[rd_ptr] into the tx_data register and increment rd_ptr.
- Simultaneous write and pop:
  - Both proceed; count is unchanged.
  - On an empty FIFO, no pop occurs (the FSM only pops when empty=0 at the cycle start), so the write lands and count becomes 1.
  - On a full FIFO, the pop frees a slot, but full is evaluated on the pre-cycle value, so the write is dropped and overflow is set.
- FSM states:
  - S_IDLE: if empty=0, pop, assert tx_start=1 for the next cycle, set busy=1, go to S_WAIT. Otherwise stay.
  - S_WAIT: tx_start=0. On tx_done_tick=1, clear busy and go to S_GAP.
  - S_GAP: one cycle, always returns to S_IDLE.
    - Guarantees tx_start never coincides with the transmitter's done-tick cycle, during which the transmitter ignores starts.
- tx_start:
  - Registered; exactly one cycle high per popped word.
  - tx_data is valid in the same cycle and remains until the next pop.
- Latency and throughput:
  - Write into an empty idle FIFO at cycle 0 gives count=1 at cycle 1 and tx_start=1 with tx_data=word at cycle 2.
  - Back-to-back words: tx_done_tick at cycle N is followed by the next tx_start at cycle N+3.
- Spurious input: tx_done_tick while in S_IDLE or S_GAP is ignored.
- Reset mid-transfer:
  - All queued words are discarded; the FSM returns to S_IDLE; tx_start deasserts immediately (asynchronous).
  - The in-flight transmitter frame is not this block's concern.

Test Plan:
- Reset, then write 0xA5 at cycle 0 -> count=1 at cycle 1; tx_start pulse with tx_data=0xA5 at cycle 2; busy=1; empty=1 at cycle 2.
- Write 0x01,0x02,0x03 back-to-back; model tx_done_tick 20 cycles after each tx_start -> three tx_start pulses in order 0x01,0x02,0x03, each exactly 3 cycles after the preceding tx_done_tick; no tx_start while busy=1.
- With ADDR_BITS=4 and the transmitter stalled (no tx_done_tick), write 18 words 0x10..0x21 -> first word popped; count reaches 16, full=1; last write (0x21) dropped; overflow=1 persists; clr_overflow pulse -> overflow=0 next cycle.
- Write while count=16 in the same cycle a pop occurs -> write dropped, overflow=1, count=15 after the cycle.
- Wrap test: push/pop 40 words 0x00..0x27 with random wr_en gaps -> output sequence identical to input, count never exceeds 16, empty=1 at end.
- Assert reset_n=0 mid-S_WAIT with count=5 -> all outputs at reset values immediately; after release, no tx_start until a new write.
